// File: rtl/uart_tl_host_bridge.sv
// -----------------------------------------------------------------------------
// uart_tl_host_bridge
//
// Turns a UART byte stream into single-beat TL-UL Get / PutFullData requests
// so an external PC can load and inspect on-chip scratchpads while the
// management core is held in reset.
//
// Command frames, multi-byte fields little-endian:
//   'W' (0x57) addr[7:0] .. addr[31:24] data[7:0] .. data[31:24]
//   'R' (0x52) addr[7:0] .. addr[31:24]
// Responses:
//   write: 'K' (0x4B), or 'E' (0x45) on d_error
//   read : 'K' + 4 data bytes LSB first, or 'E' alone on d_error
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   rx_data_i   received byte
//   rx_valid_i  one-cycle strobe qualifying rx_data_i
//   tx_data_o   response byte
//   tx_valid_o  response byte valid
//   tx_ready_i  transmitter accepts byte
//   tl_o        TL-UL A channel and d_ready
//   tl_i        TL-UL D channel and a_ready
//   busy_o      high whenever the bridge is not idle
//   drop_o      one-cycle pulse when an rx byte is discarded
//
// tlul_pkg below is a minimal TL-UL type package carrying just the fields
// this bridge drives and observes.
// -----------------------------------------------------------------------------

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    // Data access (not an instruction fetch), no integrity bits.
    localparam tl_a_user_t TL_A_USER_DEFAULT = '{
        rsvd:       5'd0,
        instr_type: 4'h9,
        cmd_intg:   7'd0,
        data_intg:  7'd0
    };

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [6:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module uart_tl_host_bridge #(
    parameter logic [7:0]  SourceId      = 8'd0,
    parameter int unsigned TimeoutCycles = 1_250_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    output logic              busy_o,
    output logic              drop_o
);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] RspOk    = 8'h4B;
    localparam logic [7:0] RspErr   = 8'h45;

    // The timeout counter only ever reaches TimeoutCycles-1 before it is
    // cleared, so clog2(TimeoutCycles) bits suffice and it cannot wrap.
    localparam int unsigned TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TimeoutLast = TW'(TimeoutCycles - 1);
    localparam bit TimeoutEn = (TimeoutCycles != 0);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        WAIT_RSP,
        TX
    } state_e;

    state_e        state_q;
    logic          is_write_q;
    logic [2:0]    cnt_q;
    logic [TW-1:0] tcnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;
    logic          a_valid_q;
    logic          d_ready_q;
    logic          tx_valid_q;
    logic [7:0]    tx_data_q;
    logic          drop_q;

    logic          timeout_hit;
    logic [2:0]    tx_last;

    assign timeout_hit = TimeoutEn && (tcnt_q == TimeoutLast);
    // Writes and error responses are a single status byte; good reads add 4.
    assign tx_last     = (is_write_q || rsp_err_q) ? 3'd0 : 3'd4;

    // NOTE: every register here, including the address/data holding
    // registers, is explicitly reset so a reset mid-frame leaves no stale
    // request fields on the bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            cnt_q      <= 3'd0;
            tcnt_q     <= '0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
            a_valid_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            drop_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge register values regardless of order.
            drop_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rx_valid_i && (rx_data_i == CmdWrite || rx_data_i == CmdRead)) begin
                        is_write_q <= (rx_data_i == CmdWrite);
                        cnt_q      <= 3'd0;
                        tcnt_q     <= '0;
                        state_q    <= ADDR;
                    end
                end

                ADDR, DATA: begin
                    if (rx_valid_i) begin
                        // A byte always beats a coincident timeout.
                        tcnt_q <= '0;
                        if (state_q == ADDR) begin
                            addr_q[8*cnt_q[1:0] +: 8] <= rx_data_i;
                        end else begin
                            data_q[8*cnt_q[1:0] +: 8] <= rx_data_i;
                        end
                        if (cnt_q == 3'd3) begin
                            cnt_q <= 3'd0;
                            if (state_q == ADDR && is_write_q) begin
                                state_q <= DATA;
                            end else begin
                                state_q   <= REQ;
                                a_valid_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end else if (timeout_hit) begin
                        tcnt_q  <= '0;
                        cnt_q   <= 3'd0;
                        state_q <= IDLE;
                    end else if (TimeoutEn) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end

                REQ: begin
                    drop_q <= rx_valid_i;
                    if (tl_i.a_ready) begin
                        a_valid_q <= 1'b0;
                        d_ready_q <= 1'b1;
                        state_q   <= WAIT_RSP;
                    end
                end

                WAIT_RSP: begin
                    drop_q <= rx_valid_i;
                    if (tl_i.d_valid) begin
                        rsp_data_q <= tl_i.d_data;
                        rsp_err_q  <= tl_i.d_error;
                        d_ready_q  <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= tl_i.d_error ? RspErr : RspOk;
                        cnt_q      <= 3'd0;
                        state_q    <= TX;
                    end
                end

                TX: begin
                    drop_q <= rx_valid_i;
                    if (tx_ready_i) begin
                        if (cnt_q == tx_last) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'd0;
                            cnt_q      <= 3'd0;
                            state_q    <= IDLE;
                        end else begin
                            // cnt_q is the index of the byte just accepted;
                            // data byte cnt_q follows it.
                            tx_data_q <= rsp_data_q[8*cnt_q[1:0] +: 8];
                            cnt_q     <= cnt_q + 3'd1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the whole struct gets a default first so no field can infer a
    // latch when later assignments are edited.
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_q;
        tl_o.a_opcode  = is_write_q ? tlul_pkg::PutFullData : tlul_pkg::Get;
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = SourceId;
        tl_o.a_address = {addr_q[31:2], 2'b00};
        tl_o.a_mask    = 4'hF;
        tl_o.a_data    = is_write_q ? data_q : 32'd0;
        tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_o.d_ready   = d_ready_q;
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = (state_q != IDLE);
    assign drop_o     = drop_q;

    // D-channel fields the bridge has no use for, plus the ignored low
    // address bits.
    logic unused_inputs;
    assign unused_inputs = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                             tl_i.d_source, tl_i.d_sink, tl_i.d_user,
                             addr_q[1:0]};

endmodule

// File: doc/uart_tl_host_bridge.md
Name: uart_tl_host_bridge

Overview:
- Byte-stream-to-TL-UL host bridge: a command-frame parser fed by the simple_uart receive byte path, emitting TL-UL Get/PutFullData on its own host port.
- Lets an external PC load and inspect the management and Vicuna scratchpads over UART while the management core is held in reset.
- Connects as an additional xbar_main host; the response bytes go back out to the UART transmit path.

Parameters:
- SourceId, 0, value driven on a_source for every request (8-bit).
- TimeoutCycles, 1_250_000, inter-byte timeout in clk_i cycles while a frame is partially received; 0 disables the timeout.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  one-cycle strobe qualifying rx_data_i
- tx_data_o  output  8  response byte
- tx_valid_o  output  1  response byte valid
- tx_ready_i  input  1  transmitter accepts byte
- tl_o  output  tlul_pkg::tl_h2d_t  TL-UL A channel and d_ready
- tl_i  input  tlul_pkg::tl_d2h_t  TL-UL D channel and a_ready
- busy_o  output  1  high in any state other than IDLE
- drop_o  output  1  one-cycle pulse when an rx byte is discarded

Behaviour:
- One clock (clk_i); reset rst_i is synchronous, active-high.
- Reset:
  - State is IDLE.
  - tl_o.a_valid=0, tl_o.d_ready=0.
  - tx_valid_o=0, tx_data_o=0, busy_o=0, drop_o=0.
  - Byte counter and timeout counter are 0.
  - Address and data registers are 0.
- Reset asserted mid-operation aborts any frame or transfer immediately.
  - A request already accepted on A is not tracked after reset.
  - Any D response arriving later is accepted only once the bridge is in WAIT_RSP, i.e. it is discarded after reset.
- Frame format, multi-byte fields little-endian:
  - Write: 0x57 ('W'), addr[7:0], addr[15:8], addr[23:16], addr[31:24], data[7:0] … data[31:24].
  - Read: 0x52 ('R'), addr[7:0] … addr[31:24].
- Response format:
  - Write: 0x4B ('K'), or 0x45 ('E') if d_error=1.
  - Read: 0x4B followed by 4 data bytes, LSB first; or 0x45 alone on d_error.
- States:
  - IDLE: on rx_valid_i with byte 0x57 or 0x52, latch is_write, clear the byte counter, go to ADDR. Any other byte is ignored silently (no drop_o).
  - ADDR: each rx_valid_i shifts the byte into addr[8*cnt +: 8] and increments cnt. After the 4th byte, go to DATA if is_write, else REQ; cnt cleared.
  - DATA: same shifting into the data register; after the 4th byte go to REQ.
  - REQ: drive a_valid=1 with:
    - a_opcode = PutFullData (0) for write, Get (4) for read.
    - a_address = {addr[31:2], 2'b00}; addr[1:0] are ignored.
    - a_size=2, a_mask=4'hF, a_source=SourceId, a_param=0.
    - a_data = data for write, 0 for read.
    - a_user = tlul_pkg::TL_A_USER_DEFAULT.
    - A-channel fields are held stable until a_ready. On a_valid&&a_ready, go to WAIT_RSP the next cycle; a_valid deasserts the same cycle.
  - WAIT_RSP: d_ready=1. On d_valid, latch d_data and d_error, then go to TX. Only one outstanding request ever exists.
  - TX: present bytes in order, first byte 'K' or 'E'. Each tx_valid_o&&tx_ready_i advances to the next byte; tx_data_o is stable while tx_valid_o&&!tx_ready_i. After the last byte is accepted, return to IDLE the next cycle.
- Latency: from the cycle of the last frame byte, a_valid rises the next cycle.
- Byte handling outside the parser states:
  - rx_valid_i in REQ, WAIT_RSP or TX: byte discarded, drop_o pulses for 1 cycle, state unchanged.
  - In IDLE and ADDR/DATA, bytes are always consumed.
- Timeout, active only in ADDR/DATA:
  - The counter increments each cycle without rx_valid_i and clears on rx_valid_i.
  - Reaching TimeoutCycles-1 returns the bridge to IDLE with no bus request and no response byte.
- Simultaneous timeout expiry and rx_valid_i: the byte wins, the counter clears, and the frame continues.
- The counter is wide enough for TimeoutCycles and never wraps.

Test Plan:
- Write frame 57 00 00 01 00 EF BE AD DE -> one A beat: opcode 0, address 0x0001_0000, a_data 0xDEADBEEF, mask F, size 2. D ack with d_error=0 -> tx byte 0x4B only, back to IDLE, busy_o=0.
- Read frame 52 04 00 01 00, D returns d_data 0x12345678 -> a_address 0x0001_0004, opcode 4. Tx bytes 4B 78 56 34 12 in order, with tx_ready_i toggling 1/0; each byte is held stable until accepted.
- Read with d_error=1 -> single tx byte 0x45.
- Unaligned address 0x0001_0003 -> a_address 0x0001_0000.
- a_ready held 0 for 10 cycles -> a_valid and all A fields stable for those 10 cycles, exactly one beat accepted.
- TimeoutCycles=16: send 57 00, then idle 16 cycles, then 52 00 00 00 00 -> no write issued; the subsequent read completes normally. Two bytes sent during WAIT_RSP -> two drop_o pulses, response unaffected.
- rst_i asserted for 1 cycle during DATA -> all outputs return to reset values the next cycle; a new frame then completes normally.
